// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants used by the fetch path.
//   XLEN      : machine word width (PC and instruction)
//   RESET_PC  : PC fetch starts from after reset
//   FQ_DEPTH  : default number of fetch-queue entries
package fetch_queue_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          FQ_DEPTH = 4;

  // One queued fetch: PC in the upper half, instruction word in the lower half.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// fq_mem: storage array for the fetch queue.
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write index
//   wdata : entry written ({pc, instr})
//   raddr : read index
//   rdata : entry at raddr, combinational read
// Contents are not reset; occupancy tracking in the parent decides validity.
module fq_mem #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO between instruction fetch and decode.
//   clk, rst          : clock and synchronous active-high reset
//   flush             : drop every queued entry (redirect)
//   in_valid/in_ready : fetch handshake, carries in_pc/in_instr
//   out_valid/out_ready : decode handshake, presents out_pc/out_instr
//   count             : current occupancy, 0..DEPTH
// A full queue refuses pushes even when the head is popped in the same cycle,
// so in_ready never depends on out_ready.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int W     = XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_pc,
  input  logic [W-1:0]             in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_pc,
  output logic [W-1:0]             out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic [2*W-1:0] rd_data;

  assign in_ready  = (count < CW'(DEPTH)) && !rst;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fq_mem #(
    .DEPTH (DEPTH),
    .DW    (2*W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign out_pc    = rd_data[2*W-1:W];
  assign out_instr = rd_data[W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a queue-based model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_pc;
  logic [W-1:0]  in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_pc;
  logic [W-1:0]  out_instr;
  logic          out_ready;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int passed = 0;
  bit chk_en = 0;

  logic [2*W-1:0] model_q[$];

  fetch_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: a plain bounded queue, updated from the inputs seen at the edge.
  always @(posedge clk) begin
    if (rst || flush) begin
      model_q.delete();
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && (model_q.size() < DEPTH);
      do_pop  = out_ready && (model_q.size() != 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({in_pc, in_instr});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 64'(count), 64'(model_q.size()));
      chk("m_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      chk("m_in_ready", 64'(in_ready), 64'(!rst && model_q.size() < DEPTH));
      if (model_q.size() != 0 && out_valid === 1'b1) begin
        chk("m_out_pc", 64'(out_pc), 64'(model_q[0][2*W-1:W]));
        chk("m_out_instr", 64'(out_instr), 64'(model_q[0][W-1:0]));
      end
    end
  end

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [W-1:0] pc, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = pc ^ 32'hA5A5_0F0F;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);
    tick();
    chk_en = 1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Fill then drain.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 32'h3000 + 32'(4*i), 0);
      tick();
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_pc", 64'(out_pc), 64'(32'h3000 + 32'(4*i)));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Pop on empty queue.
    tick();
    chk("empty_pop_count", 64'(count), 64'd0);
    chk("empty_pop_valid", 64'(out_valid), 64'd0);

    // Full with push attempt and pop: only the pop happens.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 32'h3100 + 32'(4*i), 0);
      tick();
    end
    drive(0, 0, 1, 32'h3200, 1);
    tick();
    chk("full_pp_count", 64'(count), 64'd3);
    drive(0, 0, 0, 0, 1);
    for (int i = 1; i < 4; i++) begin
      chk("full_pp_pc", 64'(out_pc), 64'(32'h3100 + 32'(4*i)));
      tick();
    end
    chk("full_pp_dropped", 64'(out_valid), 64'd0);

    // Streaming: 10 words back to back, pointers wrap twice.
    for (int i = 0; i <= 10; i++) begin
      drive(0, 0, i < 10, 32'h3000 + 32'(4*i), 1);
      if (i > 0) begin
        chk("stream_count", 64'(count), 64'd1);
        chk("stream_pc", 64'(out_pc), 64'(32'h3000 + 32'(4*(i-1))));
      end
      tick();
    end
    chk("stream_end", 64'(count), 64'd0);

    // Flush with concurrent push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h3300 + 32'(4*i), 0);
      tick();
    end
    chk("pre_flush_count", 64'(count), 64'd3);
    drive(0, 1, 1, 32'h3400, 1);
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 1, 32'h3040, 0);
    tick();
    chk("flush_next_valid", 64'(out_valid), 64'd1);
    chk("flush_next_pc", 64'(out_pc), 64'h3040);
    drive(0, 0, 1, 32'h3044, 1);
    tick();

    // Reset mid-operation (count is 1 from the previous step; add one more).
    drive(0, 0, 1, 32'h3048, 0);
    tick();
    chk("pre_rst_count", 64'(count), 64'd2);
    drive(1, 0, 0, 0, 0);
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("after_rst_in_ready", 64'(in_ready), 64'd1);

    // Randomized traffic with varying producer/consumer bias.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 500) % 3;
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 6)),
            $urandom(),
            $urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 6)));
      tick();
    end

    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
